// File: rtl/re_pkg.sv
// ============================================================================
//  Module      : re_pkg
//  Description : Flag indices, update-mask constants and the opcode-to-mask
//                decode shared by the status register stack.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package re_pkg;

    // Bit positions of the ALU-produced flags inside the status register
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_O = 3;

    // Update masks over the four ALU flags (bit order O,S,C,Z)
    localparam logic [3:0] MASK_ALL  = 4'b1111;
    localparam logic [3:0] MASK_ZCS  = 4'b0111;
    localparam logic [3:0] MASK_ZS   = 4'b0101;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    // Which ALU flags a completing operation is allowed to overwrite
    function automatic logic [3:0] upd_mask(input logic [4:0] op);
        logic [3:0] m;
        m = MASK_NONE;
        case (op) inside
            5'b00000, 5'b00001, 5'b00011,
            5'b00100, 5'b00101, 5'b00110:     m = MASK_ALL;
            5'b01000, 5'b01001:               m = MASK_ZCS;
            5'b10001, 5'b10010,
            [5'b10100 : 5'b11110]:            m = MASK_ZS;
            default:                          m = MASK_NONE;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/flag_lifo.sv
// ============================================================================
//  Module      : flag_lifo
//  Description : Small LIFO holding saved status-register images. Supports
//                push, pop and a same-cycle exchange of the top entry.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module flag_lifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_m1;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_wr_idx;
    logic             w_xchg;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full       = (r_count == CW'(DEPTH));
    assign empty      = (r_count == '0);
    assign w_count_m1 = r_count - CW'(1);
    assign w_top_idx  = w_count_m1[AW-1:0];
    assign w_wr_idx   = r_count[AW-1:0];

    // Exchange takes precedence: a pop on a non-empty stack always frees the
    // slot the push needs, so push+pop never overflows.
    assign w_xchg    = push & pop & ~empty;
    assign w_push_ok = push & ~pop & ~full | push & pop & empty;
    assign w_pop_ok  = pop & ~push & ~empty;

    assign top = empty ? '0 : r_mem[w_top_idx];

    // Storage and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_xchg) begin
            r_mem[w_top_idx] <= din;
        end else if (w_push_ok) begin
            r_mem[w_wr_idx] <= din;
            r_count         <= r_count + CW'(1);
        end else if (w_pop_ok) begin
            r_count <= w_count_m1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/status_reg_stack.sv
// ============================================================================
//  Module      : status_reg_stack
//  Description : Architectural status register fed by masked ALU flag
//                updates, a software load port and a LIFO shadow stack for
//                interrupt save/restore, with sticky overflow/underflow bits.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module status_reg_stack
    import re_pkg::*;
#(
    parameter int NFLAGS = 4,
    parameter int OPW    = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [OPW-1:0]    alu_op,
    input  logic [NFLAGS-1:0] flags_in,
    input  logic              wr_en,
    input  logic [NFLAGS-1:0] wr_data,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    output logic [NFLAGS-1:0] flags_q,
    output logic              full,
    output logic              empty,
    output logic              err_ovf,
    output logic              err_unf
);

    logic [NFLAGS-1:0] r_flags;
    logic [NFLAGS-1:0] w_flags_d;
    logic [NFLAGS-1:0] w_mask;
    logic [3:0]        w_mask4;
    logic [NFLAGS-1:0] w_top;
    logic              w_pop_ok;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              r_ovf;
    logic              r_unf;

    // The opcode table is only defined for 5-bit opcodes; other widths
    // never touch the flags from the ALU side.
    generate
        if (OPW == 5) begin : g_op5
            assign w_mask4 = upd_mask(alu_op);
        end else begin : g_opx
            assign w_mask4 = MASK_NONE;
        end
    endgenerate

    // Flags above O can only be written by software, never by the ALU
    generate
        for (genvar i = 0; i < NFLAGS; i++) begin : g_mask
            if (i < 4) begin : g_alu_bit
                assign w_mask[i] = w_mask4[i];
            end else begin : g_sw_bit
                assign w_mask[i] = 1'b0;
            end
        end
    endgenerate

    flag_lifo #(
        .WIDTH (NFLAGS),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (r_flags),
        .top   (w_top),
        .full  (full),
        .empty (empty)
    );

    assign w_pop_ok  = pop & ~empty;
    assign w_ovf_set = push & ~pop & full;
    assign w_unf_set = pop & ~push & empty;

    // Load priority: restore from stack, then software write, then ALU
    always_comb begin
        w_flags_d = r_flags;
        if (w_pop_ok) begin
            w_flags_d = w_top;
        end else if (wr_en) begin
            w_flags_d = wr_data;
        end else if (alu_valid) begin
            w_flags_d = (r_flags & ~w_mask) | (flags_in & w_mask);
        end
    end

    // Status register and sticky error bits; a fresh error beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_flags <= w_flags_d;
            r_ovf   <= (r_ovf & ~err_clr) | w_ovf_set;
            r_unf   <= (r_unf & ~err_clr) | w_unf_set;
        end
    end

    assign flags_q = r_flags;
    assign err_ovf = r_ovf;
    assign err_unf = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_status_reg_stack.sv
// ============================================================================
//  Module      : tb_status_reg_stack
//  Description : Directed and randomized bench for status_reg_stack with a
//                queue-based reference model of the flag register and stack.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_status_reg_stack;

    localparam int NF = 4;
    localparam int OW = 5;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid;
    logic [OW-1:0] alu_op;
    logic [NF-1:0] flags_in;
    logic          wr_en;
    logic [NF-1:0] wr_data;
    logic          push;
    logic          pop;
    logic          err_clr;
    logic [NF-1:0] flags_q;
    logic          full;
    logic          empty;
    logic          err_ovf;
    logic          err_unf;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [NF-1:0] m_flags;
    logic [NF-1:0] m_stk[$];
    logic          m_ovf;
    logic          m_unf;

    status_reg_stack #(
        .NFLAGS (NF),
        .OPW    (OW),
        .DEPTH  (DP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_op    (alu_op),
        .flags_in  (flags_in),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .push      (push),
        .pop       (pop),
        .err_clr   (err_clr),
        .flags_q   (flags_q),
        .full      (full),
        .empty     (empty),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
    );

    always #5 clk = ~clk;

    // Opcode table written as integer ranges
    function automatic logic [3:0] ref_mask(input int op);
        if (op == 0 || op == 1 || (op >= 3 && op <= 6)) return 4'b1111;
        if (op == 8 || op == 9)                         return 4'b0111;
        if (op == 17 || op == 18 || (op >= 20 && op <= 30)) return 4'b0101;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_flags = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock of architectural behaviour, evaluated on pre-edge inputs
    task automatic model_step();
        logic [NF-1:0] nf;
        logic [NF-1:0] msk;
        logic          novf;
        logic          nunf;
        int            n;
        n    = m_stk.size();
        nf   = m_flags;
        novf = 1'b0;
        nunf = 1'b0;
        msk  = ref_mask(int'(alu_op));
        if (push && pop && n > 0) begin
            nf = m_stk[n-1];
            m_stk[n-1] = m_flags;
        end else begin
            if (pop && n > 0)   nf = m_stk.pop_back();
            else if (wr_en)     nf = wr_data;
            else if (alu_valid) nf = (m_flags & ~msk) | (flags_in & msk);
            if (push) begin
                if (n < DP) m_stk.push_back(m_flags);
                else        novf = 1'b1;
            end
            if (pop && !push && n == 0) nunf = 1'b1;
        end
        m_flags = nf;
        m_ovf   = (m_ovf && !err_clr) || novf;
        m_unf   = (m_unf && !err_clr) || nunf;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".flags"}, 32'(flags_q), 32'(m_flags));
        chk({tag, ".full"},  32'(full),    32'(m_stk.size() == DP));
        chk({tag, ".empty"}, 32'(empty),   32'(m_stk.size() == 0));
        chk({tag, ".ovf"},   32'(err_ovf), 32'(m_ovf));
        chk({tag, ".unf"},   32'(err_unf), 32'(m_unf));
    endtask

    task automatic step(input string tag, input logic v, input logic [OW-1:0] op,
                        input logic [NF-1:0] fin, input logic we, input logic [NF-1:0] wd,
                        input logic pu, input logic po, input logic ec);
        alu_valid = v;  alu_op  = op;  flags_in = fin;
        wr_en     = we; wr_data = wd;
        push      = pu; pop     = po;  err_clr  = ec;
        @(posedge clk);
        model_step();
        #1;
        chk_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_cycles(input int cnt);
        for (int k = 0; k < cnt; k++) begin
            step("rnd",
                 ($urandom_range(0, 9) < 6),
                 OW'($urandom_range(0, 31)),
                 NF'($urandom),
                 ($urandom_range(0, 99) < 15),
                 NF'($urandom),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 6));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_op = '0; flags_in = '0; wr_en = 1'b0;
        wr_data = '0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        model_reset();
        #12;
        chk_all("reset");
        rst_n = 1'b1;

        // Masked ALU updates
        step("op00000", 1'b1, 5'b00000, 4'b1111, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("op00000.const", 32'(flags_q), 32'hF);
        step("op10001", 1'b1, 5'b10001, 4'b0000, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("op10001.const", 32'(flags_q), 32'hA);
        step("wr1111",  1'b0, '0, '0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        step("op01000", 1'b1, 5'b01000, 4'b0000, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("op01000.const", 32'(flags_q), 32'h8);
        step("op00010", 1'b1, 5'b00010, 4'b0111, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("op00010.const", 32'(flags_q), 32'h8);
        step("op11110", 1'b1, 5'b11110, 4'b0101, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step("op11111", 1'b1, 5'b11111, 4'b0000, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step("wr_over_alu", 1'b1, 5'b00000, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
        chk("wr_over_alu.const", 32'(flags_q), 32'h6);

        // Fill the stack, overflow, then drain it
        for (int i = 0; i < 4; i++) begin
            step("fill.wr",   1'b0, '0, '0, 1'b1, NF'(1 << i), 1'b0, 1'b0, 1'b0);
            step("fill.push", 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        chk("full.const", 32'(full), 32'h1);
        step("ovf", 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("ovf.const", 32'(err_ovf), 32'h1);
        for (int i = 3; i >= 0; i--) begin
            step("drain", 1'b1, 5'b00000, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0);
            chk("drain.const", 32'(flags_q), 32'(1 << i));
        end
        chk("empty.const", 32'(empty), 32'h1);
        step("unf", 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("unf.const", 32'(err_unf), 32'h1);
        step("clr_vs_err", 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        step("errclr", 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("errclr.const", 32'({err_ovf, err_unf}), 32'h0);

        // Exchange beats software write
        step("x.wr1100", 1'b0, '0, '0, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0);
        step("x.push",   1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("x.wr0011", 1'b0, '0, '0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
        step("xchg",     1'b1, 5'b00000, 4'b1111, 1'b1, 4'b0101, 1'b1, 1'b1, 1'b0);
        chk("xchg.const", 32'(flags_q), 32'hC);
        step("x.pop",    1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("x.pop.const", 32'(flags_q), 32'h3);
        step("pushpop_empty", 1'b0, '0, '0, 1'b1, 4'b1001, 1'b1, 1'b1, 1'b0);
        idle("idle");

        rand_cycles(400);

        // Asynchronous reset with three entries held
        step("ar.clr", 1'b0, '0, '0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        while (m_stk.size() > 0) step("ar.drain", 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("ar.push", 1'b0, '0, '0, 1'b1, NF'(i + 5), 1'b1, 1'b0, 1'b0);
        end
        chk("ar.count3", 32'({full, empty}), 32'h0);
        idle("ar.hold");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst");
        #3;
        rst_n = 1'b1;

        rand_cycles(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
